alu_issue: RTL
==============

# alu_issue

Register stage directly upstream of the `alu` execute unit in the 32-bit MIPS datapath. It accepts a decoded instruction, resolves read-after-write dependencies by forwarding, selects the second operand, and presents registered `a`, `b` and `op` to the ALU one cycle later. It also detects load-use hazards and issues bubbles. It honours pipeline stall and flush.

## Interface
- `n`, default 32: datapath width.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: a decoded instruction is present.
- `rs_addr`, `rt_addr`, `rd_addr` input 5 each: source and destination register numbers.
- `rs_val`, `rt_val` input n: register-file read data.
- `imm` input n: sign- or zero-extended immediate.
- `shamt` input 5: shift amount.
- `alu_src` input 1: select `imm` as operand b.
- `shift_src` input 1: shift instruction; a = rt, b = zero-extended shamt.
- `op_in` input 3: ALU opcode, passed through.
- `reg_write_in`, `mem_read_in` input 1: control bits, passed through.
- `ex_fwd_val` input n: ALU `y` of the instruction currently in EX.
- `mem_rd`, `mem_reg_write`, `mem_fwd_val` input 5/1/n: MEM-stage destination, write enable and result.
- `stall` input 1: hold stage contents.
- `flush` input 1: squash stage contents.
- `ex_valid` output 1: registered instruction valid.
- `ex_a`, `ex_b` output n: ALU operands.
- `ex_op` output 3: ALU opcode.
- `ex_rd`, `ex_reg_write`, `ex_mem_read` output 5/1/1: registered destination and control.
- `ex_store_data` output n: forwarded rt value, for stores.
- `hazard` output 1: combinational request that upstream hold its instruction.

## Operation
- **Forward select**, per source s in {rs, rt}, in priority order:
  1. If s==0, use the regfile value; register $0 is never forwarded.
  2. If `ex_valid && ex_reg_write && ex_rd==s && !ex_mem_read`, use `ex_fwd_val`.
  3. If `mem_reg_write && mem_rd==s`, use `mem_fwd_val`.
  4. Otherwise, use the regfile value.
- **Operand a:** `shift_src` ? fwd(rt) : fwd(rs).
- **Operand b:** `shift_src` ? {n-5 zeros, shamt} : `alu_src` ? imm : fwd(rt).
- **Store data:** `ex_store_data` is always fwd(rt).
- **Load-use hazard:** `hazard` = `in_valid && ex_valid && ex_mem_read && ex_rd!=0 && (ex_rd==rs_addr || ex_rd==rt_addr)`.
- **Register update priority** at each clock edge:
  1. `flush`: load a bubble.
  2. `stall`: hold all registers.
  3. `hazard`: load a bubble.
  4. Otherwise, load the incoming instruction; `ex_valid` = `in_valid`.
- **Bubble:** `ex_valid`=0, `ex_reg_write`=0, `ex_mem_read`=0, `ex_rd`=0. Data fields load 0.
- **Invalid input:** when `in_valid`=0 and the stage loads, `ex_reg_write` and `ex_mem_read` are forced to 0.

## Timing
- Latency is 1 cycle from input to `ex_*` outputs.
- The forward select and `hazard` paths are purely combinational.
- Reset (`rst_n`=0, asynchronous) clears every `ex_*` output to 0. `hazard` is then 0 because `ex_valid`=0.
- A reset asserted mid-stall or mid-hazard discards the held instruction.
- A hazard lasts exactly 1 cycle: the bubble clears `ex_mem_read`. The next cycle takes the loaded value via `mem_fwd_val`.
- `stall` and `hazard` asserted together: the stage holds, so the load stays in EX and `hazard` remains asserted.
- `flush` and `stall` asserted together: the stage flushes.
- A loaded `ex_op` is stable for the whole EX cycle. The ALU output `zero` is not registered here.

## Configuration
- Macro `ALU_ISSUE_FWD_EN`.
- **Defined:** forwarding as described above.
- **Undefined:**
  - The forward muxes are removed; fwd(s) = regfile value.
  - `hazard` asserts on any RAW dependency: `in_valid && s!=0`, and either `ex_valid && ex_reg_write && ex_rd==s`, or `mem_reg_write && mem_rd==s`.
  - Stall/bubble behaviour is otherwise identical.

## Test plan
- **Reset:** pulse `rst_n` low mid-cycle with `ex_valid`=1 -> all `ex_*` outputs are 0 immediately, without waiting for a clock edge.
- **Add-immediate:** rs_val=5, imm=7, alu_src=1, op_in=010 -> next cycle ex_a=5, ex_b=7, ex_op=010, ex_valid=1.
- **EX forward:** EX holds rd=8 with `reg_write`, ex_fwd_val=0x10. Incoming rs=8 with stale rs_val=1 -> ex_a=0x10. With rs=0 and a matching rd=0 -> ex_a = rs_val, with no forward.
- **Forward priority:** EX and MEM both target rd=9, ex_fwd_val=3, mem_fwd_val=4 -> operand=3.
- **Load-use:** EX holds a load with rd=4; incoming rt=4 -> `hazard`=1 for one cycle, a bubble is issued, and the retried instruction gets mem_fwd_val.
- **Shift, stall and flush:**
  - shift_src=1, rt_val=0x1, shamt=31 -> ex_a=1, ex_b=31.
  - stall=1 for 3 cycles -> outputs are unchanged.
  - stall=1 with flush=1 -> ex_valid=0.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: issue register in front of the ALU. It forwards EX/MEM results
// to the source operands, selects operand b, detects load-use hazards and
// issues bubbles. It honours stall and flush.
// Optional feature macro: ALU_ISSUE_FWD_EN. When it is defined, the forwarding
// muxes are present. When it is undefined, any RAW dependency on EX or MEM
// raises hazard instead of being forwarded.
module alu_issue #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [4:0]   rs_addr,
  input  logic [4:0]   rt_addr,
  input  logic [4:0]   rd_addr,
  input  logic [n-1:0] rs_val,
  input  logic [n-1:0] rt_val,
  input  logic [n-1:0] imm,
  input  logic [4:0]   shamt,
  input  logic         alu_src,
  input  logic         shift_src,
  input  logic [2:0]   op_in,
  input  logic         reg_write_in,
  input  logic         mem_read_in,
  input  logic [n-1:0] ex_fwd_val,
  input  logic [4:0]   mem_rd,
  input  logic         mem_reg_write,
  input  logic [n-1:0] mem_fwd_val,
  input  logic         stall,
  input  logic         flush,
  output logic         ex_valid,
  output logic [n-1:0] ex_a,
  output logic [n-1:0] ex_b,
  output logic [2:0]   ex_op,
  output logic [4:0]   ex_rd,
  output logic         ex_reg_write,
  output logic         ex_mem_read,
  output logic [n-1:0] ex_store_data,
  output logic         hazard
);

  localparam int unsigned AW  = 5;
  localparam int unsigned OPW = 3;

  logic           ex_valid_q, ex_valid_d;
  logic [n-1:0]   ex_a_q, ex_a_d;
  logic [n-1:0]   ex_b_q, ex_b_d;
  logic [OPW-1:0] ex_op_q, ex_op_d;
  logic [AW-1:0]  ex_rd_q, ex_rd_d;
  logic           ex_reg_write_q, ex_reg_write_d;
  logic           ex_mem_read_q, ex_mem_read_d;
  logic [n-1:0]   ex_store_data_q, ex_store_data_d;

  logic [n-1:0]   fwd_rs_c, fwd_rt_c;
  logic [n-1:0]   op_a_c, op_b_c;
  logic           hazard_c;

`ifdef ALU_ISSUE_FWD_EN
  // Forward select per source: $0 never forwards, EX (non-load) beats MEM
  always_comb begin
    fwd_rs_c = rs_val;
    fwd_rt_c = rt_val;
    if (rs_addr != AW'(0)) begin
      if (ex_valid_q && ex_reg_write_q && (ex_rd_q == rs_addr) && !ex_mem_read_q)
        fwd_rs_c = ex_fwd_val;
      else if (mem_reg_write && (mem_rd == rs_addr))
        fwd_rs_c = mem_fwd_val;
    end
    if (rt_addr != AW'(0)) begin
      if (ex_valid_q && ex_reg_write_q && (ex_rd_q == rt_addr) && !ex_mem_read_q)
        fwd_rt_c = ex_fwd_val;
      else if (mem_reg_write && (mem_rd == rt_addr))
        fwd_rt_c = mem_fwd_val;
    end
  end

  // Load-use hazard: a load in EX cannot be forwarded to its consumer
  always_comb begin
    hazard_c = in_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != AW'(0)) &&
               ((ex_rd_q == rs_addr) || (ex_rd_q == rt_addr));
  end
`else
  logic unused_fwd_vals;
  assign unused_fwd_vals = ^{ex_fwd_val, mem_fwd_val};

  // No forwarding network: sources always come straight from the regfile
  always_comb begin
    fwd_rs_c = rs_val;
    fwd_rt_c = rt_val;
  end

  // Any RAW dependency on an in-flight EX or MEM write must wait
  always_comb begin
    logic raw_rs, raw_rt;
    raw_rs = (rs_addr != AW'(0)) &&
             ((ex_valid_q && ex_reg_write_q && (ex_rd_q == rs_addr)) ||
              (mem_reg_write && (mem_rd == rs_addr)));
    raw_rt = (rt_addr != AW'(0)) &&
             ((ex_valid_q && ex_reg_write_q && (ex_rd_q == rt_addr)) ||
              (mem_reg_write && (mem_rd == rt_addr)));
    hazard_c = in_valid && (raw_rs || raw_rt);
  end
`endif

  // Operand selection: shifts take rt as a and zero-extended shamt as b
  always_comb begin
    op_a_c = shift_src ? fwd_rt_c : fwd_rs_c;
    if (shift_src)
      op_b_c = n'(shamt);
    else if (alu_src)
      op_b_c = imm;
    else
      op_b_c = fwd_rt_c;
  end

  // Next-state: flush > stall > hazard bubble > load
  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_a_d          = ex_a_q;
    ex_b_d          = ex_b_q;
    ex_op_d         = ex_op_q;
    ex_rd_d         = ex_rd_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_read_d   = ex_mem_read_q;
    ex_store_data_d = ex_store_data_q;
    if (flush || (!stall && hazard_c)) begin
      ex_valid_d      = 1'b0;
      ex_a_d          = '0;
      ex_b_d          = '0;
      ex_op_d         = '0;
      ex_rd_d         = '0;
      ex_reg_write_d  = 1'b0;
      ex_mem_read_d   = 1'b0;
      ex_store_data_d = '0;
    end else if (!stall) begin
      ex_valid_d      = in_valid;
      ex_a_d          = op_a_c;
      ex_b_d          = op_b_c;
      ex_op_d         = op_in;
      ex_rd_d         = rd_addr;
      ex_reg_write_d  = in_valid && reg_write_in;
      ex_mem_read_d   = in_valid && mem_read_in;
      ex_store_data_d = fwd_rt_c;
    end
  end

  // Stage register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_a_q          <= '0;
      ex_b_q          <= '0;
      ex_op_q         <= '0;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_store_data_q <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_a_q          <= ex_a_d;
      ex_b_q          <= ex_b_d;
      ex_op_q         <= ex_op_d;
      ex_rd_q         <= ex_rd_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_store_data_q <= ex_store_data_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_a          = ex_a_q;
  assign ex_b          = ex_b_q;
  assign ex_op         = ex_op_q;
  assign ex_rd         = ex_rd_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_store_data = ex_store_data_q;
  assign hazard        = hazard_c;

endmodule
